inst_issue_ctrl: RTL and testbench

//  Instruction issue controller, directly downstream of the program-counter/instruction BRAM stage.

---
 rtl/tpu_isa_pkg.sv | 42 ++++
 rtl/inst_decode.sv | 28 ++
 rtl/inst_issue_ctrl.sv | 179 +++++++++++++++++
 tb/tb_inst_issue_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// TPU instruction-set constants shared by the issue stage and later pipeline stages.
// Opcode values, field widths, unit selector and issue FSM state encodings.
package tpu_isa_pkg;

  localparam int OPC_BITS = 8;

  localparam logic [OPC_BITS-1:0] OPC_NOP   = 8'h00;
  localparam logic [OPC_BITS-1:0] OPC_LOAD  = 8'h01;
  localparam logic [OPC_BITS-1:0] OPC_MAC   = 8'h02;
  localparam logic [OPC_BITS-1:0] OPC_STORE = 8'h03;
  localparam logic [OPC_BITS-1:0] OPC_HALT  = 8'hFF;

  typedef enum logic [1:0] {
    U_LOAD  = 2'd0,
    U_MAC   = 2'd1,
    U_STORE = 2'd2,
    U_NONE  = 2'd3
  } unit_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_INST,
    S_DECODE,
    S_DISPATCH,
    S_EXEC,
    S_HALTED
  } state_e;

  // Opcode occupies the top byte; operand is everything below it.
  function automatic int opc_lsb(input int inst_bits);
    return inst_bits - OPC_BITS;
  endfunction

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/inst_decode.sv
// Combinational opcode decoder: classifies an opcode into nop/halt/unit/illegal.
// Reused by later pipeline stages that need the same classification.
module inst_decode
  import tpu_isa_pkg::*;
(
  input  logic [OPC_BITS-1:0] i_opcode,
  output logic                o_is_nop,
  output logic                o_is_halt,
  output unit_e               o_unit_sel,
  output logic                o_illegal
);

  always_comb begin
    o_is_nop   = 1'b0;
    o_is_halt  = 1'b0;
    o_unit_sel = U_NONE;
    o_illegal  = 1'b0;
    unique case (1'b1)
      (i_opcode == OPC_NOP):   o_is_nop   = 1'b1;
      (i_opcode == OPC_HALT):  o_is_halt  = 1'b1;
      (i_opcode == OPC_LOAD):  o_unit_sel = U_LOAD;
      (i_opcode == OPC_MAC):   o_unit_sel = U_MAC;
      (i_opcode == OPC_STORE): o_unit_sel = U_STORE;
      default:                 o_illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_issue_ctrl.sv
// Instruction issue controller: fetch, decode, dispatch to LOAD/MAC/STORE, await done.
// Define INST_ISSUE_PERF_EN to add the perf_issued / perf_stall counters.
module inst_issue_ctrl
  import tpu_isa_pkg::*;
#(
  parameter int INST_BITS     = 128,
  parameter int FETCH_TIMEOUT = 16,
  parameter int EXEC_TIMEOUT  = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          fetch_req,
  input  logic                          inst_valid,
  input  logic [INST_BITS-1:0]          instruction,
  output logic [INST_BITS-OPC_BITS-1:0] cmd_operand,
  output logic                          ld_cmd_valid,
  input  logic                          ld_cmd_ready,
  input  logic                          ld_done,
  output logic                          mac_cmd_valid,
  input  logic                          mac_cmd_ready,
  input  logic                          mac_done,
  output logic                          st_cmd_valid,
  input  logic                          st_cmd_ready,
  input  logic                          st_done,
  output logic                          busy,
  output logic                          halted,
  output logic                          err_illegal,
  output logic                          err_timeout
`ifdef INST_ISSUE_PERF_EN
  ,
  output logic [31:0]                   perf_issued,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int OPD_BITS = INST_BITS - OPC_BITS;
  localparam int OPC_LSB  = opc_lsb(INST_BITS);
  localparam int TMAX     = (FETCH_TIMEOUT > EXEC_TIMEOUT) ?
                            FETCH_TIMEOUT : EXEC_TIMEOUT;
  localparam int TW       = (clogb2(TMAX) < 1) ? 1 : clogb2(TMAX);

  localparam logic [TW-1:0] FETCH_LIM = TW'(FETCH_TIMEOUT - 1);
  localparam logic [TW-1:0] EXEC_LIM  = TW'(EXEC_TIMEOUT - 1);

  state_e                r_state;
  logic [OPC_BITS-1:0]   r_opcode;
  logic [OPD_BITS-1:0]   r_operand;
  unit_e                 r_sel;
  logic [TW-1:0]         r_timer;
  logic                  r_err_ill;
  logic                  r_err_to;

  logic                  w_is_nop;
  logic                  w_is_halt;
  unit_e                 w_sel;
  logic                  w_illegal;
  logic                  w_rdy;
  logic                  w_done;
  logic                  w_disp;

  inst_decode u_dec (
    .i_opcode   (r_opcode),
    .o_is_nop   (w_is_nop),
    .o_is_halt  (w_is_halt),
    .o_unit_sel (w_sel),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_rdy  = 1'b0;
    w_done = 1'b0;
    unique case (r_sel)
      U_LOAD:  begin w_rdy = ld_cmd_ready;  w_done = ld_done;  end
      U_MAC:   begin w_rdy = mac_cmd_ready; w_done = mac_done; end
      U_STORE: begin w_rdy = st_cmd_ready;  w_done = st_done;  end
      default: begin w_rdy = 1'b0;          w_done = 1'b0;     end
    endcase
  end

  assign w_disp        = (r_state == S_DISPATCH);
  assign fetch_req     = (r_state == S_FETCH);
  assign ld_cmd_valid  = w_disp && (r_sel == U_LOAD);
  assign mac_cmd_valid = w_disp && (r_sel == U_MAC);
  assign st_cmd_valid  = w_disp && (r_sel == U_STORE);
  assign busy          = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign halted        = (r_state == S_HALTED);
  assign cmd_operand   = r_operand;
  assign err_illegal   = r_err_ill;
  assign err_timeout   = r_err_to;

  // Timer is zero during the FETCH cycle and the cycle after accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_operand <= '0;
      r_sel     <= U_NONE;
      r_timer   <= '0;
      r_err_ill <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      if (r_timer != '1) r_timer <= r_timer + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_timer <= '0;
          end
        end
        S_FETCH: r_state <= S_WAIT_INST;
        S_WAIT_INST: begin
          if (inst_valid) begin
            r_opcode  <= instruction[INST_BITS-1 -: OPC_BITS];
            r_operand <= instruction[OPC_LSB-1:0];
            r_state   <= S_DECODE;
          end else if (r_timer == FETCH_LIM) begin
            r_err_to <= 1'b1;
            r_state  <= S_HALTED;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            w_illegal: begin
              r_err_ill <= 1'b1;
              r_state   <= S_HALTED;
            end
            w_is_halt: r_state <= S_HALTED;
            w_is_nop: begin
              r_state <= S_FETCH;
              r_timer <= '0;
            end
            default: begin
              r_sel   <= w_sel;
              r_state <= S_DISPATCH;
            end
          endcase
        end
        S_DISPATCH: begin
          if (w_rdy) begin
            r_timer <= '0;
            r_state <= w_done ? S_FETCH : S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_done) begin
            r_state <= S_FETCH;
            r_timer <= '0;
          end else if (r_timer == EXEC_LIM) begin
            r_err_to <= 1'b1;
            r_state  <= S_HALTED;
          end
        end
        S_HALTED: begin
          if (start) begin
            r_err_ill <= 1'b0;
            r_err_to  <= 1'b0;
            r_state   <= S_FETCH;
            r_timer   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef INST_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (w_disp) begin
      if (w_rdy) perf_issued <= perf_issued + 32'd1;
      else       perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Scoreboard bench for inst_issue_ctrl: PC and unit models, random programs,
// directed sequences for stall, illegal opcode, fetch timeout, same-cycle done, reset.
module tb_inst_issue_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         inst_valid = 1'b0;
  logic [127:0] instruction = '0;
  logic         fetch_req;
  logic [119:0] cmd_operand;
  logic         ld_cmd_valid, mac_cmd_valid, st_cmd_valid;
  logic [2:0]   rdy = '0;
  logic [2:0]   dn = '0;
  logic         busy, halted, err_illegal, err_timeout;
`ifdef INST_ISSUE_PERF_EN
  logic [31:0]  perf_issued, perf_stall;
`endif
  logic [2:0]   v;

  assign v = {st_cmd_valid, mac_cmd_valid, ld_cmd_valid};

  always #5 clk = ~clk;

  inst_issue_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fetch_req     (fetch_req),
    .inst_valid    (inst_valid),
    .instruction   (instruction),
    .cmd_operand   (cmd_operand),
    .ld_cmd_valid  (ld_cmd_valid),
    .ld_cmd_ready  (rdy[0]),
    .ld_done       (dn[0]),
    .mac_cmd_valid (mac_cmd_valid),
    .mac_cmd_ready (rdy[1]),
    .mac_done      (dn[1]),
    .st_cmd_valid  (st_cmd_valid),
    .st_cmd_ready  (rdy[2]),
    .st_done       (dn[2]),
    .busy          (busy),
    .halted        (halted),
    .err_illegal   (err_illegal),
    .err_timeout   (err_timeout)
`ifdef INST_ISSUE_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stall    (perf_stall)
`endif
  );

  typedef struct {
    int           unit;
    logic [119:0] opd;
  } cmd_t;

  cmd_t         exp_q[$];
  int           nvec = 0;
  int           nerr = 0;

  logic [127:0] mem [1024];
  int           wp = 0;
  int           pc = 0;
  int           exp_pc = 0;

  bit           pc_mute = 0;
  int           pc_cnt = 0;
  int           stall_plan = 0;
  bit           rdy_always = 0;
  bit           spur_all = 0;
  int           done_fix [3] = '{-1, -1, -1};
  int           active = -1;
  int           done_cnt = 0;
  int           env_d;

  int           fetch_cnt = 0;
  int           vlen = 0;
  int           last_vlen = 0;
  bit           exp_fetch = 0;
  bit           prev_hold = 0;
  logic [119:0] prev_opd;
  int           perf_iss_m = 0;
  int           perf_st_m = 0;
  int           mu;
  cmd_t         me;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] op);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    mem[wp] = {op, t[119:0]};
    wp++;
  endtask

  // PC model and execution-unit models.
  initial forever begin
    @(posedge clk);
    #1;
    inst_valid  = 1'b0;
    instruction = {$urandom, $urandom, $urandom, $urandom};
    if (pc_cnt > 0) begin
      pc_cnt--;
      if (pc_cnt == 0) begin
        inst_valid  = 1'b1;
        instruction = mem[pc];
        pc++;
      end
    end
    if (fetch_req && !pc_mute && !reset) pc_cnt = $urandom_range(1, 3);
    rdy = '0;
    dn  = '0;
    if (active >= 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        dn[active] = 1'b1;
        active = -1;
      end
    end
    for (int u = 0; u < 3; u++) begin
      if (v[u]) begin
        if (stall_plan > 0) stall_plan--;
        else if (rdy_always || ($urandom_range(0, 1) == 1)) begin
          rdy[u] = 1'b1;
          env_d = (done_fix[u] >= 0) ? done_fix[u] : $urandom_range(0, 4);
          if (env_d == 0) dn[u] = 1'b1;
          else begin
            active   = u;
            done_cnt = env_d;
          end
        end
      end
    end
    for (int u = 0; u < 3; u++) begin
      if (!v[u] && u != active && !dn[u]) begin
        if (spur_all ? (active >= 0) : ($urandom_range(0, 7) == 0))
          dn[u] = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted command.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_fetch  = 0;
      prev_hold  = 0;
      vlen       = 0;
      perf_iss_m = 0;
      perf_st_m  = 0;
    end else begin
      if (fetch_req) fetch_cnt++;
      if (exp_fetch) chk("fetch_after_same_cycle_done", fetch_req, 1);
      exp_fetch = 0;
      if (active >= 0) chk("no_fetch_during_exec", fetch_req, 0);
      if (v != 3'b000) begin
        chk("onehot_valid", ($countones(v) == 1), 1);
        if (prev_hold) chk("operand_stable", cmd_operand, prev_opd);
        vlen++;
        mu = v[0] ? 0 : (v[1] ? 1 : 2);
        if (rdy[mu]) begin
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_cmd: got unit %0d, expected none", mu);
          end else begin
            me = exp_q.pop_front();
            chk("cmd_unit", mu, me.unit);
            chk("cmd_operand", cmd_operand, me.opd);
          end
          if (dn[mu]) exp_fetch = 1;
          last_vlen = vlen;
          vlen      = 0;
          prev_hold = 0;
          perf_iss_m++;
        end else begin
          prev_hold = 1;
          prev_opd  = cmd_operand;
          perf_st_m++;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Reference walk over program memory, then run until HALTED.
  task automatic go();
    int           a;
    int           nf;
    int           f0;
    int           n;
    bit           ill;
    bit           stop;
    logic [127:0] w;
    cmd_t         c;
    a = exp_pc; nf = 0; ill = 0; stop = 0;
    while (!stop) begin
      w = mem[a];
      a++;
      nf++;
      if (w[127:120] == 8'h00) begin
      end else if (w[127:120] >= 8'h01 && w[127:120] <= 8'h03) begin
        c.unit = int'(w[127:120]) - 1;
        c.opd  = w[119:0];
        exp_q.push_back(c);
      end else if (w[127:120] == 8'hFF) begin
        stop = 1;
      end else begin
        ill  = 1;
        stop = 1;
      end
    end
    exp_pc = a;
    f0 = fetch_cnt;
    pulse_start();
    @(negedge clk);
    chk("start_fetch", fetch_req, 1);
    chk("start_clears_illegal", err_illegal, 0);
    chk("start_clears_timeout", err_timeout, 0);
    n = 0;
    while (!halted && n < 3000) begin
      @(posedge clk);
      #1 start = busy && ($urandom_range(0, 9) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("halted", halted, 1);
    chk("busy_off", busy, 0);
    chk("err_illegal", err_illegal, ill);
    chk("err_timeout", err_timeout, 0);
    chk("fetch_count", fetch_cnt - f0, nf);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
`ifdef INST_ISSUE_PERF_EN
    chk("perf_issued", perf_issued, perf_iss_m);
    chk("perf_stall", perf_stall, perf_st_m);
`endif
  endtask

  initial begin
    bit seen;
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_cmd_operand", cmd_operand, 0);
    chk("rst_valids", v, 0);

    rdy_always = 1;
    done_fix   = '{3, 3, 3};
    put(8'h01); put(8'h02); put(8'h03); put(8'hFF);
    go();

    done_fix = '{-1, 3, 0};
    spur_all = 1;
    put(8'h03); put(8'h02); put(8'hFF);
    go();
    spur_all = 0;
    done_fix = '{-1, -1, -1};

    put(8'h7E); put(8'h01); put(8'hFF);
    go();
    go();

    pc_mute = 1;
    pulse_start();
    @(negedge clk);
    chk("to_fetch_req", fetch_req, 1);
    repeat (15) @(negedge clk);
    chk("to_not_yet", err_timeout, 0);
    @(negedge clk);
    chk("to_err_timeout", err_timeout, 1);
    chk("to_halted", halted, 1);
    pc_mute = 0;
    put(8'h00); put(8'h02); put(8'hFF);
    go();

    stall_plan = 1000;
    put(8'h01); put(8'hFF);
    pulse_start();
    n = 0;
    while (!ld_cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_dispatch", ld_cmd_valid, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    stall_plan = 0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_ld_valid", ld_cmd_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_halted", halted, 0);
    seen = fetch_req;
    repeat (5) begin
      @(negedge clk);
      seen |= fetch_req;
    end
    chk("rst_mid_no_fetch", seen, 0);
    exp_pc = pc;
    go();

    stall_plan = 5;
    put(8'h02); put(8'hFF);
    go();
    chk("mac_valid_len", last_vlen, 6);
`ifdef INST_ISSUE_PERF_EN
    chk("mac_perf_stall", perf_stall, 5);
`endif
    rdy_always = 0;

    for (int p = 0; p < 25; p++) begin
      int  len;
      int  r;
      bit  term;
      len  = $urandom_range(1, 6);
      term = 0;
      for (int i = 0; i < len && !term; i++) begin
        r = $urandom_range(0, 99);
        if (r < 15)      put(8'h00);
        else if (r < 40) put(8'h01);
        else if (r < 65) put(8'h02);
        else if (r < 90) put(8'h03);
        else if (r < 95) begin
          put(8'($urandom_range(4, 254)));
          term = 1;
        end else put(8'h00);
      end
      if (!term) put(8'hFF);
      go();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
